reward_unit: RTL and testbench

Reward-computation stage of the Q-learning routing datapath. It starts when the previous stage signals completion on `done_prev`. It then reads the routing tables held in the shared byte-wide memory (`mem`) for the chosen action and best next hop, and computes a signed reward. Finally it publishes an 80-bit reward record and raises `done_reward` to the next stage.

---
 rtl/reward_unit_pkg.sv | 42 ++++
 rtl/mem.sv | 28 ++
 rtl/reward_unit_arith.sv | 38 +++
 rtl/reward_unit.sv | 137 +++++++++++++
 tb/tb_reward_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/reward_unit_pkg.sv
// Shared constants, FSM encoding and record layout for the reward stage.
// REWARD_CLUSTER_PENALTY_EN enables the cluster-ID read and penalty.
package reward_unit_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 1024;
    localparam logic [WORD_WIDTH-1:0] ADDR_MASK = WORD_WIDTH'(MEM_DEPTH - 1);

    localparam logic [WORD_WIDTH-1:0] Q_BASE   = 16'h0100;
    localparam logic [WORD_WIDTH-1:0] HOP_BASE = 16'h0200;
    localparam logic [WORD_WIDTH-1:0] CLU_BASE = 16'h0300;

    localparam int R_BASE = 100;
    localparam int R_HOP  = 10;
    localparam int R_CLU  = 50;

    localparam int REC_WIDTH       = 5 * WORD_WIDTH;
    localparam int REC_Q_LSB       = 0;
    localparam int REC_REWARD_LSB  = 1 * WORD_WIDTH;
    localparam int REC_ACTION_LSB  = 2 * WORD_WIDTH;
    localparam int REC_CLUSTER_LSB = 3 * WORD_WIDTH;
    localparam int REC_NODE_LSB    = 4 * WORD_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_QA,
        ST_RD_QB,
        ST_RD_HOP,
        ST_RD_CLU,
        ST_CALC,
        ST_DONE
    } state_t;

    // Table entries are 2 bytes wide; the memory only decodes 10 bits.
    function automatic logic [WORD_WIDTH-1:0] entry_addr(
        input logic [WORD_WIDTH-1:0] base,
        input logic [WORD_WIDTH-1:0] id
    );
        return (base + (id << 1)) & ADDR_MASK;
    endfunction

endpackage

// File: rtl/mem.sv
// Shared 1024 x 8 routing-table memory, little-endian 16-bit port.
// Read data is registered one edge after the address is presented.
module mem
    import reward_unit_pkg::*;
(
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic [WORD_WIDTH-1:0] mem_data_out
);

    logic [7:0] bytes [MEM_DEPTH];
    logic [9:0] a_lo;
    logic [9:0] a_hi;

    assign a_lo = address[9:0];
    assign a_hi = a_lo + 10'd1;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            bytes[a_lo] <= wr_data[7:0];
            bytes[a_hi] <= wr_data[15:8];
        end
        mem_data_out <= {bytes[a_hi], bytes[a_lo]};
    end

endmodule

// File: rtl/reward_unit_arith.sv
// Reward arithmetic: base minus hop and cluster penalties, saturated.
// The cluster term is gated by clu_en (REWARD_CLUSTER_PENALTY_EN at top).
module reward_arith #(
    parameter int WORD_WIDTH = reward_unit_pkg::WORD_WIDTH,
    parameter int R_BASE     = reward_unit_pkg::R_BASE,
    parameter int R_HOP      = reward_unit_pkg::R_HOP,
    parameter int R_CLU      = reward_unit_pkg::R_CLU
) (
    input  logic [WORD_WIDTH-1:0] hop,
    input  logic [WORD_WIDTH-1:0] clu,
    input  logic [WORD_WIDTH-1:0] my_cluster,
    input  logic                  clu_en,
    output logic [WORD_WIDTH-1:0] reward
);

    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (WORD_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (WORD_WIDTH - 1));

    logic                clu_mismatch;
    logic signed [31:0]  hop_s;
    logic signed [31:0]  penalty;
    logic signed [31:0]  wide;

    always_comb begin
        clu_mismatch = (clu != my_cluster);
        hop_s        = $signed(32'(hop));
        penalty      = (clu_en && clu_mismatch) ? 32'(R_CLU) : 32'sd0;
        wide         = 32'(R_BASE) - 32'(R_HOP) * hop_s - penalty;
        if (wide > SAT_MAX) begin
            reward = SAT_MAX[WORD_WIDTH-1:0];
        end else if (wide < SAT_MIN) begin
            reward = SAT_MIN[WORD_WIDTH-1:0];
        end else begin
            reward = wide[WORD_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/reward_unit.sv
// Reward stage: reads Q/HOP/CLU tables, computes and publishes a reward record.
// REWARD_CLUSTER_PENALTY_EN adds the RD_CLU read and the foreign-cluster penalty.
module reward_unit #(
    parameter int WORD_WIDTH                = reward_unit_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] Q_BASE   = reward_unit_pkg::Q_BASE,
    parameter logic [WORD_WIDTH-1:0] HOP_BASE = reward_unit_pkg::HOP_BASE,
    parameter logic [WORD_WIDTH-1:0] CLU_BASE = reward_unit_pkg::CLU_BASE,
    parameter int R_BASE                    = reward_unit_pkg::R_BASE,
    parameter int R_HOP                     = reward_unit_pkg::R_HOP,
    parameter int R_CLU                     = reward_unit_pkg::R_CLU
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WORD_WIDTH-1:0]   _action,
    input  logic [WORD_WIDTH-1:0]   _besthop,
    output logic [WORD_WIDTH-1:0]   address,
    input  logic [WORD_WIDTH-1:0]   mem_data_out,
    output logic [5*WORD_WIDTH-1:0] reward_data_out,
    input  logic [WORD_WIDTH-1:0]   MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0]   MY_CLUSTER_ID,
    input  logic                    done_prev,
    output logic                    done_reward
);

    import reward_unit_pkg::*;

`ifdef REWARD_CLUSTER_PENALTY_EN
    localparam logic CLU_EN = 1'b1;
`else
    localparam logic CLU_EN = 1'b0;
`endif

    state_t                state;
    logic                  half;
    logic [WORD_WIDTH-1:0] act_q;
    logic [WORD_WIDTH-1:0] bh_q;
    logic [WORD_WIDTH-1:0] node_q;
    logic [WORD_WIDTH-1:0] clus_q;
    logic [WORD_WIDTH-1:0] q_a;
    logic [WORD_WIDTH-1:0] q_b;
    logic [WORD_WIDTH-1:0] hop_q;
    logic [WORD_WIDTH-1:0] clu_q;
    logic [WORD_WIDTH-1:0] reward;

    reward_arith #(
        .WORD_WIDTH (WORD_WIDTH),
        .R_BASE     (R_BASE),
        .R_HOP      (R_HOP),
        .R_CLU      (R_CLU)
    ) u_arith (
        .hop        (hop_q),
        .clu        (clu_q),
        .my_cluster (clus_q),
        .clu_en     (CLU_EN),
        .reward     (reward)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            half            <= 1'b0;
            address         <= '0;
            reward_data_out <= '0;
            done_reward     <= 1'b0;
            act_q           <= '0;
            bh_q            <= '0;
            node_q          <= '0;
            clus_q          <= '0;
            q_a             <= '0;
            q_b             <= '0;
            hop_q           <= '0;
            clu_q           <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (done_prev) begin
                        act_q   <= _action;
                        bh_q    <= _besthop;
                        node_q  <= MY_NODE_ID;
                        clus_q  <= MY_CLUSTER_ID;
                        address <= entry_addr(Q_BASE, _action);
                        half    <= 1'b0;
                        state   <= ST_RD_QA;
                    end
                end
                ST_RD_QA: begin
                    half <= ~half;
                    if (half) begin
                        q_a     <= mem_data_out;
                        address <= entry_addr(Q_BASE, bh_q);
                        state   <= ST_RD_QB;
                    end
                end
                ST_RD_QB: begin
                    half <= ~half;
                    if (half) begin
                        q_b     <= mem_data_out;
                        address <= entry_addr(HOP_BASE, act_q);
                        state   <= ST_RD_HOP;
                    end
                end
                ST_RD_HOP: begin
                    half <= ~half;
                    if (half) begin
                        hop_q <= mem_data_out;
`ifdef REWARD_CLUSTER_PENALTY_EN
                        address <= entry_addr(CLU_BASE, act_q);
                        state   <= ST_RD_CLU;
`else
                        state   <= ST_CALC;
`endif
                    end
                end
                ST_RD_CLU: begin
                    half <= ~half;
                    if (half) begin
                        clu_q <= mem_data_out;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    reward_data_out <= {node_q, clus_q, act_q, reward, q_b};
                    done_reward     <= 1'b1;
                    state           <= ST_DONE;
                end
                ST_DONE: begin
                    if (!done_prev) begin
                        done_reward <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reward_unit.sv
// Directed bench for reward_unit with a behavioural table memory.
// Expectations follow REWARD_CLUSTER_PENALTY_EN when it is defined.
module tb_reward_unit;

    import reward_unit_pkg::*;

`ifdef REWARD_CLUSTER_PENALTY_EN
    localparam int  EXP_LAT = 9;
    localparam bit  PEN_EN  = 1'b1;
`else
    localparam int  EXP_LAT = 7;
    localparam bit  PEN_EN  = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tb_action;
    logic [15:0] tb_besthop;
    logic [15:0] tb_node;
    logic [15:0] tb_cluster;
    logic        done_prev = 1'b0;
    logic [15:0] address;
    logic [15:0] mem_data_out;
    logic [79:0] reward_data_out;
    logic        done_reward;

    logic        wr_en = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] mem_addr;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    assign mem_addr = wr_en ? tb_addr : address;

    mem u_mem (
        .clock        (clock),
        .wr_en        (wr_en),
        .address      (mem_addr),
        .wr_data      (wr_data),
        .mem_data_out (mem_data_out)
    );

    reward_unit dut (
        .clock           (clock),
        .reset           (reset),
        ._action         (tb_action),
        ._besthop        (tb_besthop),
        .address         (address),
        .mem_data_out    (mem_data_out),
        .reward_data_out (reward_data_out),
        .MY_NODE_ID      (tb_node),
        .MY_CLUSTER_ID   (tb_cluster),
        .done_prev       (done_prev),
        .done_reward     (done_reward)
    );

    typedef struct {
        string       name;
        logic [15:0] hop;
        logic [15:0] clu;
        logic [15:0] rew_en;
        logic [15:0] rew_dis;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] exp_rec(input logic [15:0] rew);
        return {16'h0002, 16'h0003, 16'h0005, rew, 16'h0040};
    endfunction

    function automatic logic [15:0] pick(input logic [15:0] en,
                                         input logic [15:0] dis);
        return PEN_EN ? en : dis;
    endfunction

    task automatic drive_nominal();
        tb_action  = 16'h0005;
        tb_besthop = 16'h0006;
        tb_node    = 16'h0002;
        tb_cluster = 16'h0003;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        tb_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    // Starts a run; scrambles inputs after edge 0 to prove they are latched.
    task automatic run_seq(input int drop_at, output int lat,
                           output logic [15:0] addr0);
        @(negedge clock);
        drive_nominal();
        done_prev = 1'b1;
        @(posedge clock);
        #1;
        addr0      = address;
        tb_action  = 16'h0077;
        tb_besthop = 16'h0001;
        tb_node    = 16'h00AA;
        tb_cluster = 16'h0009;
        lat = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #1;
            if (done_reward) begin
                lat = e;
                break;
            end
            if (e == drop_at) done_prev = 1'b0;
        end
        drive_nominal();
    endtask

    task automatic drop_and_check(input string name);
        @(negedge clock);
        done_prev = 1'b0;
        @(posedge clock);
        #1;
        check(name, 80'(done_reward), 80'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [15:0] a0;
        logic [15:0] rew;

        drive_nominal();
        repeat (2) @(posedge clock);
        #1;
        check("rst_address", 80'(address), 80'h0);
        check("rst_record", reward_data_out, 80'h0);
        check("rst_done", 80'(done_reward), 80'h0);
        @(negedge clock);
        reset = 1'b0;

        mem_write(16'h010A, 16'h0011);
        mem_write(16'h010C, 16'h0040);

        vecs[0] = '{"hop2_same_clu", 16'd2,     16'd3, 16'h0050, 16'h0050};
        vecs[1] = '{"hop2_foreign",  16'd2,     16'd4, 16'h001E, 16'h0050};
        vecs[2] = '{"hop20_foreign", 16'd20,    16'd4, 16'hFF6A, 16'hFF9C};
        vecs[3] = '{"hop_sat",       16'hFFFF,  16'd3, 16'h8000, 16'h8000};
        vecs[4] = '{"hop0_foreign",  16'd0,     16'd4, 16'h0032, 16'h0064};

        foreach (vecs[i]) begin
            mem_write(16'h020A, vecs[i].hop);
            mem_write(16'h030A, vecs[i].clu);
            run_seq(0, lat, a0);
            rew = pick(vecs[i].rew_en, vecs[i].rew_dis);
            check({vecs[i].name, "_lat"}, 80'(lat), 80'(EXP_LAT));
            check({vecs[i].name, "_rec"}, reward_data_out, exp_rec(rew));
            drop_and_check({vecs[i].name, "_fall"});
        end

        // done_prev held high in DONE: no restart, record stable.
        mem_write(16'h020A, 16'd2);
        mem_write(16'h030A, 16'd4);
        rew = pick(16'h001E, 16'h0050);
        run_seq(0, lat, a0);
        check("hold_lat", 80'(lat), 80'(EXP_LAT));
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            check("hold_done", 80'(done_reward), 80'(1'b1));
            check("hold_rec", reward_data_out, exp_rec(rew));
        end
        drop_and_check("hold_fall");
        run_seq(0, lat, a0);
        check("restart_addr", 80'(a0), 80'h010A);
        check("restart_lat", 80'(lat), 80'(EXP_LAT));
        check("restart_rec", reward_data_out, exp_rec(rew));
        drop_and_check("restart_fall");

        // done_prev dropped mid-read: record still produced, one-cycle pulse.
        run_seq(2, lat, a0);
        check("middrop_lat", 80'(lat), 80'(EXP_LAT));
        check("middrop_rec", reward_data_out, exp_rec(rew));
        @(posedge clock);
        #1;
        check("middrop_pulse", 80'(done_reward), 80'(1'b0));

        // Reset at edge 5, then restart with done_prev still high.
        @(negedge clock);
        drive_nominal();
        done_prev = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_address", 80'(address), 80'h0);
        check("midrst_record", reward_data_out, 80'h0);
        check("midrst_done", 80'(done_reward), 80'h0);
        check("midrst_fsm", 80'(dut.state), 80'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        lat = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clock);
            #1;
            if (done_reward) begin
                lat = e;
                break;
            end
        end
        check("postrst_lat", 80'(lat), 80'(EXP_LAT));
        check("postrst_rec", reward_data_out, exp_rec(rew));
        drop_and_check("postrst_fall");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
